alu_share_arbiter: RTL and testbench

ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

---
 rtl/alu_share_arbiter.sv | 103 ++++++++++
 tb/tb_alu_share_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external ALU among four requesters.
// Grants one operation at a time, waits ALU_LAT cycles, then returns the captured result.
module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ALU_LAT    = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [3:0]                req,
  input  logic [3:0]                en_mask,
  input  logic [4*DATA_WIDTH-1:0]   req_A,
  input  logic [4*DATA_WIDTH-1:0]   req_B,
  input  logic [11:0]               req_op,
  output logic [3:0]                gnt,
  output logic [3:0]                rsp_valid,
  output logic [1:0]                rsp_id,
  output logic [DATA_WIDTH-1:0]     rsp_Result,
  output logic [2:0]                rsp_flags,
  output logic [DATA_WIDTH-1:0]     alu_A,
  output logic [DATA_WIDTH-1:0]     alu_B,
  output logic [2:0]                alu_ALUop,
  input  logic [DATA_WIDTH-1:0]     alu_Result,
  input  logic                      alu_Overflow,
  input  logic                      alu_CarryOut,
  input  logic                      alu_Zero,
  output logic                      busy
);

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned OP_W  = 3;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   cur;
  logic [CNT_W-1:0]   cnt;

  logic [NREQ-1:0]    elig_c;
  logic               found_c;
  logic [IDX_W-1:0]   sel_c;

  // Round-robin search starting just after the last granted index
  always_comb begin
    elig_c  = req & en_mask;
    found_c = 1'b0;
    sel_c   = ptr;
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (!found_c && elig_c[IDX_W'(ptr + IDX_W'(k))]) begin
        found_c = 1'b1;
        sel_c   = IDX_W'(ptr + IDX_W'(k));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= IDX_W'(NREQ - 1);
      cur        <= '0;
      cnt        <= '0;
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_id     <= '0;
      rsp_Result <= '0;
      rsp_flags  <= '0;
      alu_A      <= '0;
      alu_B      <= '0;
      alu_ALUop  <= '0;
      busy       <= 1'b0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      if (state == IDLE) begin
        if (found_c) begin
          gnt       <= NREQ'(1) << sel_c;
          alu_A     <= req_A[32'(sel_c)*DATA_WIDTH +: DATA_WIDTH];
          alu_B     <= req_B[32'(sel_c)*DATA_WIDTH +: DATA_WIDTH];
          alu_ALUop <= req_op[32'(sel_c)*OP_W +: OP_W];
          ptr       <= sel_c;
          cur       <= sel_c;
          cnt       <= '0;
          state     <= EXEC;
          busy      <= 1'b1;
        end
      end else begin
        cnt <= CNT_W'(cnt + CNT_W'(1));
        // Final latency cycle: capture the ALU outputs and release the ALU
        if (cnt == CNT_W'(ALU_LAT - 1)) begin
          rsp_Result <= alu_Result;
          rsp_flags  <= {alu_Overflow, alu_CarryOut, alu_Zero};
          rsp_id     <= cur;
          rsp_valid  <= NREQ'(1) << cur;
          state      <= IDLE;
          busy       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: one instance at ALU_LAT=1, one at ALU_LAT=3,
// each driven by a small behavioural ALU.
module tb_alu_share_arbiter;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {Overflow, CarryOut, Zero, Result}
  function automatic logic [DW+2:0] alu_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [2:0] op);
    logic [DW:0]   s;
    logic [DW-1:0] r;
    logic          o, c;
    s = '0; o = 1'b0; c = 1'b0;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b110: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[DW-1:0];
        c = ~s[DW];
        o = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      default: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[DW-1:0];
        c = s[DW];
        o = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
    endcase
    return {o, c, (r == '0), r};
  endfunction

  // Instance with ALU_LAT = 1
  logic          r1_n, busy1, ao1, ac1, az1;
  logic [3:0]    req1, en1, gnt1, rv1;
  logic [4*DW-1:0] a1, b1;
  logic [11:0]   op1;
  logic [1:0]    id1;
  logic [DW-1:0] res1, aa1, ab1, ar1;
  logic [2:0]    fl1, aop1;

  assign {ao1, ac1, az1, ar1} = alu_model(aa1, ab1, aop1);

  alu_share_arbiter #(.DATA_WIDTH(DW), .ALU_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(r1_n), .req(req1), .en_mask(en1),
    .req_A(a1), .req_B(b1), .req_op(op1),
    .gnt(gnt1), .rsp_valid(rv1), .rsp_id(id1), .rsp_Result(res1), .rsp_flags(fl1),
    .alu_A(aa1), .alu_B(ab1), .alu_ALUop(aop1),
    .alu_Result(ar1), .alu_Overflow(ao1), .alu_CarryOut(ac1), .alu_Zero(az1),
    .busy(busy1)
  );

  // Instance with ALU_LAT = 3
  logic          r3_n, busy3, ao3, ac3, az3;
  logic [3:0]    req3, en3, gnt3, rv3;
  logic [4*DW-1:0] a3, b3;
  logic [11:0]   op3;
  logic [1:0]    id3;
  logic [DW-1:0] res3, aa3, ab3, ar3;
  logic [2:0]    fl3, aop3;

  assign {ao3, ac3, az3, ar3} = alu_model(aa3, ab3, aop3);

  alu_share_arbiter #(.DATA_WIDTH(DW), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .reset_n(r3_n), .req(req3), .en_mask(en3),
    .req_A(a3), .req_B(b3), .req_op(op3),
    .gnt(gnt3), .rsp_valid(rv3), .rsp_id(id3), .rsp_Result(res3), .rsp_flags(fl3),
    .alu_A(aa3), .alu_B(ab3), .alu_ALUop(aop3),
    .alu_Result(ar3), .alu_Overflow(ao3), .alu_CarryOut(ac3), .alu_Zero(az3),
    .busy(busy3)
  );

  task automatic reset1();
    r1_n = 1'b0;
    tick();
    r1_n = 1'b1;
  endtask

  initial begin
    logic [3:0] e;
    int unsigned busycnt;

    r1_n = 1'b0; req1 = '0; en1 = '0; a1 = '0; b1 = '0; op1 = '0;
    r3_n = 1'b0; req3 = '0; en3 = '0; a3 = '0; b3 = '0; op3 = '0;
    tick();
    tick();
    check("rst_gnt", 64'(gnt1), 64'h0);
    check("rst_rsp_valid", 64'(rv1), 64'h0);
    check("rst_rsp_id", 64'(id1), 64'h0);
    check("rst_rsp_result", 64'(res1), 64'h0);
    check("rst_rsp_flags", 64'(fl1), 64'h0);
    check("rst_alu_a", 64'(aa1), 64'h0);
    check("rst_alu_op", 64'(aop1), 64'h0);
    check("rst_busy", 64'(busy1), 64'h0);
    check("rst_busy3", 64'(busy3), 64'h0);
    r1_n = 1'b1;
    r3_n = 1'b1;

    // Single add, latency 1
    a1[31:0] = 32'd5; b1[31:0] = 32'd7; op1[2:0] = 3'b010;
    en1 = 4'b1111; req1 = 4'b0001;
    tick();
    check("t1_gnt", 64'(gnt1), 64'h1);
    check("t1_busy", 64'(busy1), 64'h1);
    check("t1_alu_a", 64'(aa1), 64'd5);
    check("t1_alu_op", 64'(aop1), 64'h2);
    req1 = 4'b0000;
    tick();
    check("t1_gnt_clr", 64'(gnt1), 64'h0);
    check("t1_rsp_valid", 64'(rv1), 64'h1);
    check("t1_rsp_id", 64'(id1), 64'h0);
    check("t1_result", 64'(res1), 64'd12);
    check("t1_flags", 64'(fl1), 64'h0);
    check("t1_busy_idle", 64'(busy1), 64'h0);
    tick();
    check("t1_rsp_pulse", 64'(rv1), 64'h0);
    check("t1_result_hold", 64'(res1), 64'd12);
    check("t1_alu_a_hold", 64'(aa1), 64'd5);

    // All four requesting: round-robin 0,1,2,3,0 spaced two cycles apart
    reset1();
    for (int i = 0; i < 4; i++) begin
      a1[i*32 +: 32] = 32'(i + 1);
      b1[i*32 +: 32] = 32'(10 * i);
      op1[i*3 +: 3]  = 3'b010;
    end
    req1 = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      e = 4'b0001 << (n % 4);
      tick();
      check("rr_gnt", 64'(gnt1), 64'(e));
      check("rr_no_rsp", 64'(rv1), 64'h0);
      tick();
      check("rr_gnt_gap", 64'(gnt1), 64'h0);
      check("rr_rsp_valid", 64'(rv1), 64'(e));
      check("rr_rsp_id", 64'(id1), 64'(n % 4));
      check("rr_result", 64'(res1), 64'(11 * (n % 4) + 1));
    end

    // Requester 3 masked off: only requester 1 ever granted
    reset1();
    req1 = 4'b1010; en1 = 4'b0010;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("mask_gnt", 64'(gnt1), 64'h2);
      tick();
      check("mask_rsp", 64'(rv1), 64'h2);
      check("mask_gnt_gap", 64'(gnt1), 64'h0);
    end

    // Reset while executing: no response, pointer back to 3
    reset1();
    en1 = 4'b1111; req1 = 4'b0100;
    tick();
    check("rx_gnt", 64'(gnt1), 64'h4);
    r1_n = 1'b0; req1 = 4'b1101;
    tick();
    check("rx_rsp_valid", 64'(rv1), 64'h0);
    check("rx_gnt", 64'(gnt1), 64'h0);
    check("rx_busy", 64'(busy1), 64'h0);
    check("rx_result", 64'(res1), 64'h0);
    check("rx_alu_a", 64'(aa1), 64'h0);
    check("rx_rsp_id", 64'(id1), 64'h0);
    r1_n = 1'b1;
    tick();
    check("rx_next_gnt", 64'(gnt1), 64'h1);
    req1 = 4'b0000;

    // Latency 3, signed overflow; en_mask dropped mid-operation
    a3[31:0] = 32'h7FFF_FFFF; b3[31:0] = 32'h1; op3[2:0] = 3'b010;
    en3 = 4'b1111; req3 = 4'b0001;
    busycnt = 0;
    tick();
    check("l3_gnt", 64'(gnt3), 64'h1);
    busycnt += 32'(busy3);
    en3 = 4'b0000;
    for (int k = 2; k <= 6; k++) begin
      tick();
      busycnt += 32'(busy3);
      check("l3_gnt_zero", 64'(gnt3), 64'h0);
      if (k == 4) begin
        check("l3_rsp_valid", 64'(rv3), 64'h1);
        check("l3_rsp_id", 64'(id3), 64'h0);
        check("l3_result", 64'(res3), 64'h8000_0000);
        check("l3_flags", 64'(fl3), 64'h4);
      end else begin
        check("l3_rsp_idle", 64'(rv3), 64'h0);
      end
    end
    check("l3_busy_cycles", 64'(busycnt), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
